mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single-port unified `memory` between the instruction-fetch requester (`fetch`) and a data requester (loader/load-store path). It grants one requester at a time, breaks multi-word requests into single-word memory beats with auto-incremented addresses, and returns read data with per-requester valid strobes. It also generates the fetch `stall` whenever fetch is waiting for the port.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width.

Clock and reset (one clock; reset is synchronous and active-low):
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous active-low reset.

Fetch requester:
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_WIDTH  start byte address.
- `if_access_size`  in  2  burst size: 00 = 1, 01 = 4, 10 = 8, 11 = 16 words.
- `if_gnt`  out  1  one-cycle pulse when the request is accepted.
- `if_rvalid`  out  1  `rdata` holds a fetch word this cycle.
- `stall`  out  1  drives `fetch.stall`.

Data requester:
- `dm_req`  in  1  data request; held until `dm_gnt`.
- `dm_addr`  in  ADDR_WIDTH  start byte address.
- `dm_access_size`  in  2  burst size, same encoding as `if_access_size`.
- `dm_rw`  in  1  1 = read, 0 = write.
- `dm_wdata`  in  DATA_WIDTH  write word; consumed on `dm_wready`.
- `dm_gnt`  out  1  one-cycle acceptance pulse.
- `dm_wready`  out  1  current write beat accepted this cycle.
- `dm_rvalid`  out  1  `rdata` holds a data word this cycle.

Shared and memory side:
- `rdata`  out  DATA_WIDTH  read data, shared by both requesters.
- `mem_address`  out  ADDR_WIDTH  memory address.
- `mem_data_in`  out  DATA_WIDTH  memory write data.
- `mem_access_size`  out  2  tied to 2'b00.
- `mem_rw`  out  1  1 = read, 0 = write.
- `mem_enable`  out  1  memory enable.
- `mem_busy`  in  1  memory busy.
- `mem_data_out`  in  DATA_WIDTH  memory read data.

## Operation
- **FSM states:** IDLE, IF_XFER, DM_XFER, RD_TAIL.
- **IDLE**
  - Arbitrates among requests that are high at the clock edge.
  - Only `dm_req`: go to DM_XFER. Only `if_req`: go to IF_XFER. Both: priority rule, see Configuration.
  - On entering a transfer, latch address (bits [1:0] forced to 0), size, rw and owner.
  - Load the beat counter with N−1, where N = 1, 4, 8 or 16.
- **XFER states**
  - `mem_enable`=1; `mem_address` = latched address + 4×beat_index, wrapping modulo 2^ADDR_WIDTH.
  - A beat is accepted in any cycle with `mem_busy`=0. `mem_busy`=1 holds address, data and counter.
  - Writes: `mem_data_in` = `dm_wdata` combinationally; `dm_wready` = (state==DM_XFER & !rw & !`mem_busy`).
  - After the last accepted beat: writes go to IDLE; reads go to RD_TAIL for one cycle to return the final word, then IDLE.
- **Read return**
  - `rdata` = `mem_data_out` registered.
  - Owner's rvalid is high in the cycle after each accepted read beat; exactly N rvalid pulses per read request.
- **`stall`** = `if_req` & !(state==IF_XFER). Combinational; low in IDLE when `if_req`=0.
- **Withdrawn requests:** a `req` dropped before its `gnt` is treated as withdrawn; no transfer occurs. A `req` dropped after `gnt` has no effect; the burst completes.
- **Request inputs** are sampled only in IDLE. Requests that change during a transfer do not affect it.

## Timing
- **Reset values:** all outputs 0; `mem_rw`=1 (read idle); state IDLE; round-robin pointer favours data.
- **Grant latency:** request seen in IDLE at edge E → state XFER, `gnt` pulse and first `mem_enable` in the cycle after E.
- **Read latency:** first rvalid comes 2 cycles after the request edge, with no busy stalls.
- **Throughput:**
  - Single-word read occupies 3 cycles: XFER, RD_TAIL, IDLE.
  - Burst of N with no stalls: N XFER cycles, plus 1 RD_TAIL cycle for reads, plus 1 IDLE cycle.
- **Reset mid-transfer:** the next edge returns to IDLE and drops `mem_enable`; remaining beats are abandoned; no further rvalid or wready.
- **Simultaneous requests in IDLE:** exactly one `gnt`; the loser's `stall` (fetch) stays high until it is granted.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, the grant goes to the requester not served last; the pointer updates on each grant.
  - Fetch cannot be starved by back-to-back data requests.
- Undefined: fixed priority, data always beats fetch; no pointer register.

## Test plan
- **Single fetch read:** reset, then `if_req`, `if_addr`=0x80020000, size 00 → `if_gnt` in cycle 1; `mem_address`=0x80020000, `mem_rw`=1; one `if_rvalid` in cycle 2 with `rdata` = preloaded word; `stall` low from cycle 1.
- **Write burst:** `dm_req`, `dm_rw`=0, size 01 at 0x80020010; `mem_busy` high for 1 cycle on beat 2 → 4 `dm_wready` pulses at addresses 0x80020010, 0x80020014, 0x80020018, 0x8002001C; beat 2 held 2 cycles; then IDLE with no rvalid.
- **Contention:** `if_req` and `dm_req` both high, twice back-to-back.
  - Without the macro: data granted both times; `stall` high throughout.
  - With the macro: data, then fetch.
- **Wrap-around:** read size 01 at 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; 4 rvalid pulses.
- **Reset mid-burst:** 16-word fetch; assert `reset_n`=0 after beat 5 → next cycle `mem_enable`=0, `if_rvalid`=0, all outputs at reset values; a new request after reset is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// The arbiter connects through the slave modport; the requesters/memory side use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [1:0]            if_access_size;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic                  stall;

  logic                  dm_req;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [1:0]            dm_access_size;
  logic                  dm_rw;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_wready;
  logic                  dm_rvalid;

  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [1:0]            mem_access_size;
  logic                  mem_rw;
  logic                  mem_enable;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  if_req, if_addr, if_access_size,
    output if_gnt, if_rvalid, stall,
    input  dm_req, dm_addr, dm_access_size, dm_rw, dm_wdata,
    output dm_gnt, dm_wready, dm_rvalid,
    output rdata, mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    input  mem_busy, mem_data_out
  );

  modport master (
    output if_req, if_addr, if_access_size,
    input  if_gnt, if_rvalid, stall,
    output dm_req, dm_addr, dm_access_size, dm_rw, dm_wdata,
    input  dm_gnt, dm_wready, dm_rvalid,
    input  rdata, mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    output mem_busy, mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data path,
// splitting bursts into word beats. Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_XFER = 2'd1;
  localparam logic [1:0] DM_XFER = 2'd2;
  localparam logic [1:0] RD_TAIL = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            beats_left;
  logic                  rw_q;
  logic                  if_gnt_q;
  logic                  dm_gnt_q;
  logic                  if_rvalid_q;
  logic                  dm_rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic in_xfer;
  logic grant_if;
  logic grant_dm;

  function automatic logic [3:0] last_index(input logic [1:0] size);
    case (size)
      2'b00:   return 4'd0;
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  assign in_xfer = (state == IF_XFER) || (state == DM_XFER);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when data won the most recent grant, so fetch wins the next tie.
  logic fav_fetch;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (bus.if_req && (!bus.dm_req || fav_fetch)) grant_if = 1'b1;
    else if (bus.dm_req)                          grant_dm = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                                   fav_fetch <= 1'b0;
    else if ((state == IDLE) && (grant_if || grant_dm)) fav_fetch <= grant_dm;
  end
`else
  assign grant_dm = bus.dm_req;
  assign grant_if = bus.if_req && !bus.dm_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      rw_q        <= 1'b1;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= (state == IF_XFER) && !bus.mem_busy;
      dm_rvalid_q <= (state == DM_XFER) && rw_q && !bus.mem_busy;
      if (in_xfer && rw_q && !bus.mem_busy) rdata_q <= bus.mem_data_out;

      case (state)
        IDLE: begin
          if (grant_dm) begin
            state      <= DM_XFER;
            cur_addr   <= bus.dm_addr & ~ADDR_WIDTH'(3);
            beats_left <= last_index(bus.dm_access_size);
            rw_q       <= bus.dm_rw;
            dm_gnt_q   <= 1'b1;
          end else if (grant_if) begin
            state      <= IF_XFER;
            cur_addr   <= bus.if_addr & ~ADDR_WIDTH'(3);
            beats_left <= last_index(bus.if_access_size);
            rw_q       <= 1'b1;
            if_gnt_q   <= 1'b1;
          end
        end
        IF_XFER, DM_XFER: begin
          if (!bus.mem_busy) begin
            if (beats_left == 4'd0) begin
              // Reads need one more cycle to present the final registered word.
              state <= rw_q ? RD_TAIL : IDLE;
            end else begin
              beats_left <= beats_left - 4'd1;
              cur_addr   <= cur_addr + ADDR_WIDTH'(4);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt          = if_gnt_q;
  assign bus.dm_gnt          = dm_gnt_q;
  assign bus.if_rvalid       = if_rvalid_q;
  assign bus.dm_rvalid       = dm_rvalid_q;
  assign bus.rdata           = rdata_q;
  assign bus.stall           = bus.if_req && (state != IF_XFER);
  assign bus.dm_wready       = (state == DM_XFER) && !rw_q && !bus.mem_busy;

  assign bus.mem_enable      = in_xfer;
  assign bus.mem_rw          = in_xfer ? rw_q : 1'b1;
  assign bus.mem_address     = in_xfer ? cur_addr : '0;
  assign bus.mem_data_in     = ((state == DM_XFER) && !rw_q) ? bus.dm_wdata : '0;
  assign bus.mem_access_size = 2'b00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model (queue of expected
// memory beats) checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit SECOND_GRANT_IS_DM = 1'b0;
`else
  localparam bit SECOND_GRANT_IS_DM = 1'b1;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic        is_dm;
  } beat_t;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.mem_data_out = data_fn(bus.mem_address);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  beat_t       beat_q[$];
  bit          model_valid = 0;
  bit          m_tail = 0;
  bit          m_if_gnt = 0, m_dm_gnt = 0, m_if_rv = 0, m_dm_rv = 0;
  logic [31:0] m_rdata = '0;
  bit          m_last_was_dm = 0;
  int          burst_len [4] = '{1, 4, 8, 16};

  always @(negedge clock) begin : model
    beat_t       b;
    bit          exp_en, idle_now, tail_next, pick_dm, exp_stall;
    logic [31:0] base;
    int          n;

    if (model_valid) begin
      exp_en = (beat_q.size() != 0);
      check("mem_enable", bus.mem_enable, exp_en);
      if (exp_en) begin
        check("mem_address", bus.mem_address, beat_q[0].addr);
        check("mem_rw", bus.mem_rw, beat_q[0].rw);
        if (!beat_q[0].rw) begin
          check("mem_data_in", bus.mem_data_in, bus.dm_wdata);
          check("dm_wready", bus.dm_wready, !bus.mem_busy);
        end else begin
          check("dm_wready_rd", bus.dm_wready, 0);
        end
      end else begin
        check("mem_rw_idle", bus.mem_rw, 1);
        check("mem_address_idle", bus.mem_address, 0);
        check("dm_wready_idle", bus.dm_wready, 0);
      end
      check("if_gnt", bus.if_gnt, m_if_gnt);
      check("dm_gnt", bus.dm_gnt, m_dm_gnt);
      check("if_rvalid", bus.if_rvalid, m_if_rv);
      check("dm_rvalid", bus.dm_rvalid, m_dm_rv);
      if (m_if_rv || m_dm_rv) check("rdata", bus.rdata, m_rdata);
      exp_stall = bus.if_req && !(exp_en && !beat_q[0].is_dm);
      check("stall", bus.stall, exp_stall);
      check("mem_access_size", bus.mem_access_size, 0);
    end

    // Work out what the next cycle must look like.
    if (!reset_n) begin
      beat_q.delete();
      m_tail = 0; m_if_gnt = 0; m_dm_gnt = 0; m_if_rv = 0; m_dm_rv = 0;
      m_rdata = '0; m_last_was_dm = 0;
      model_valid = 1;
    end else begin
      idle_now  = (beat_q.size() == 0) && !m_tail;
      tail_next = 0;
      m_if_gnt = 0; m_dm_gnt = 0; m_if_rv = 0; m_dm_rv = 0;
      if (beat_q.size() != 0 && !bus.mem_busy) begin
        b = beat_q.pop_front();
        if (b.rw) begin
          m_if_rv = !b.is_dm;
          m_dm_rv = b.is_dm;
          m_rdata = data_fn(b.addr);
          tail_next = (beat_q.size() == 0);
        end
      end
      if (idle_now && (bus.if_req || bus.dm_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_dm = bus.dm_req && (!bus.if_req || !m_last_was_dm);
`else
        pick_dm = bus.dm_req;
`endif
        m_last_was_dm = pick_dm;
        if (pick_dm) begin
          base = {bus.dm_addr[31:2], 2'b00};
          n = burst_len[bus.dm_access_size];
          for (int i = 0; i < n; i++) beat_q.push_back('{base + 32'(4 * i), bus.dm_rw, 1'b1});
          m_dm_gnt = 1;
        end else begin
          base = {bus.if_addr[31:2], 2'b00};
          n = burst_len[bus.if_access_size];
          for (int i = 0; i < n; i++) beat_q.push_back('{base + 32'(4 * i), 1'b1, 1'b0});
          m_if_gnt = 1;
        end
      end
      m_tail = tail_next;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFC0 | ($urandom & 32'h3F);
    return $urandom;
  endfunction

  initial begin
    int          wr_cnt, busy_hold, rv_cnt, stall_gap, beats, dm_left;
    logic [31:0] wr_addr [4];
    logic [31:0] rd_addr [4];
    bit          order[$];
    bit          if_done;

    // NOTE: bench inputs are driven with blocking assignments just after the clock edge.
    reset_n = 1'b0;
    bus.if_req = 0; bus.if_addr = '0; bus.if_access_size = '0;
    bus.dm_req = 0; bus.dm_addr = '0; bus.dm_access_size = '0; bus.dm_rw = 1; bus.dm_wdata = '0;
    bus.mem_busy = 0;
    tick(); tick();
    check("rst_mem_enable", bus.mem_enable, 0);
    check("rst_mem_rw", bus.mem_rw, 1);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_rdata", bus.rdata, 0);
    reset_n = 1'b1;
    tick();

    // Single fetch read
    bus.if_req = 1; bus.if_addr = 32'h8002_0000; bus.if_access_size = 2'b00;
    tick();
    check("fetch_gnt", bus.if_gnt, 1);
    check("fetch_addr", bus.mem_address, 32'h8002_0000);
    check("fetch_rw", bus.mem_rw, 1);
    check("fetch_stall", bus.stall, 0);
    bus.if_req = 0;
    tick();
    check("fetch_rvalid", bus.if_rvalid, 1);
    check("fetch_rdata", bus.rdata, 32'h1357_6420);
    tick();
    check("fetch_rvalid_end", bus.if_rvalid, 0);
    tick();

    // Write burst of 4 with one busy cycle on beat 2
    bus.dm_req = 1; bus.dm_rw = 0; bus.dm_access_size = 2'b01; bus.dm_addr = 32'h8002_0010;
    bus.dm_wdata = 32'hD000_0000;
    wr_cnt = 0; busy_hold = 0; rv_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.mem_busy = (c == 2);
      bus.dm_wdata = 32'hD000_0000 + 32'(c);
      #1;
      if (bus.dm_gnt) bus.dm_req = 0;
      if (bus.mem_enable && bus.mem_address == 32'h8002_0014) busy_hold++;
      if (bus.if_rvalid || bus.dm_rvalid) rv_cnt++;
      if (bus.dm_wready) begin
        if (wr_cnt < 4) wr_addr[wr_cnt] = bus.mem_address;
        wr_cnt++;
      end
    end
    bus.mem_busy = 0;
    check("wr_count", wr_cnt, 4);
    check("wr_addr0", wr_addr[0], 32'h8002_0010);
    check("wr_addr1", wr_addr[1], 32'h8002_0014);
    check("wr_addr2", wr_addr[2], 32'h8002_0018);
    check("wr_addr3", wr_addr[3], 32'h8002_001C);
    check("wr_beat2_hold", busy_hold, 2);
    check("wr_no_rvalid", rv_cnt, 0);
    check("wr_idle_after", bus.mem_enable, 0);
    tick();

    // Contention: both request, data requests twice back-to-back
    bus.if_req = 1; bus.if_addr = 32'h8002_0200; bus.if_access_size = 2'b00;
    bus.dm_req = 1; bus.dm_rw = 1; bus.dm_addr = 32'h8002_0300; bus.dm_access_size = 2'b00;
    dm_left = 2; if_done = 0; stall_gap = 0;
    for (int c = 0; c < 30 && (dm_left != 0 || !if_done); c++) begin
      tick();
      if (!if_done && !bus.if_gnt && bus.stall !== 1'b1) stall_gap++;
      if (bus.dm_gnt) begin
        order.push_back(1'b1);
        dm_left--;
        if (dm_left == 0) bus.dm_req = 0;
      end
      if (bus.if_gnt) begin
        order.push_back(1'b0);
        if_done = 1;
        bus.if_req = 0;
      end
    end
    bus.if_req = 0; bus.dm_req = 0;
    check("contention_grants", order.size(), 3);
    if (order.size() >= 2) begin
      check("contention_first_dm", order[0], 1);
      check("contention_second", order[1], SECOND_GRANT_IS_DM);
    end
    check("contention_stall", stall_gap, 0);
    repeat (3) tick();

    // Wrap-around read burst
    bus.dm_req = 1; bus.dm_rw = 1; bus.dm_access_size = 2'b01; bus.dm_addr = 32'hFFFF_FFF8;
    beats = 0; rv_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.dm_gnt) bus.dm_req = 0;
      if (bus.dm_rvalid) rv_cnt++;
      if (bus.mem_enable && !bus.mem_busy) begin
        if (beats < 4) rd_addr[beats] = bus.mem_address;
        beats++;
      end
    end
    check("wrap_beats", beats, 4);
    check("wrap_addr0", rd_addr[0], 32'hFFFF_FFF8);
    check("wrap_addr1", rd_addr[1], 32'hFFFF_FFFC);
    check("wrap_addr2", rd_addr[2], 32'h0000_0000);
    check("wrap_addr3", rd_addr[3], 32'h0000_0004);
    check("wrap_rvalid", rv_cnt, 4);
    tick();

    // Reset in the middle of a 16-word fetch
    bus.if_req = 1; bus.if_addr = 32'h8002_0100; bus.if_access_size = 2'b11;
    beats = 0;
    for (int c = 0; c < 20 && beats < 5; c++) begin
      tick();
      if (bus.if_gnt) bus.if_req = 0;
      if (bus.mem_enable) beats++;
    end
    check("midrst_beats_seen", beats, 5);
    reset_n = 1'b0;
    tick();
    check("midrst_enable", bus.mem_enable, 0);
    check("midrst_rvalid", bus.if_rvalid, 0);
    check("midrst_gnt", bus.if_gnt, 0);
    check("midrst_mem_rw", bus.mem_rw, 1);
    check("midrst_address", bus.mem_address, 0);
    check("midrst_rdata", bus.rdata, 0);
    check("midrst_stall", bus.stall, 0);
    reset_n = 1'b1;
    bus.if_req = 1; bus.if_addr = 32'h8002_0040; bus.if_access_size = 2'b00;
    tick();
    check("postrst_gnt", bus.if_gnt, 1);
    check("postrst_addr", bus.mem_address, 32'h8002_0040);
    bus.if_req = 0;
    tick();
    check("postrst_rvalid", bus.if_rvalid, 1);
    check("postrst_rdata", bus.rdata, 32'h1317_6460);
    repeat (2) tick();

    // Random traffic with busy stalls, withdrawals and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset_n      = ($urandom_range(0, 599) != 0);
      bus.mem_busy = ($urandom_range(0, 3) == 0);
      bus.dm_wdata = $urandom;
      if (bus.if_req && bus.if_gnt) bus.if_req = 0;
      else if (bus.if_req && $urandom_range(0, 15) == 0) bus.if_req = 0;
      else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        bus.if_req = 1;
        bus.if_addr = rand_addr();
        bus.if_access_size = 2'($urandom_range(0, 3));
      end
      if (bus.dm_req && bus.dm_gnt) bus.dm_req = 0;
      else if (bus.dm_req && $urandom_range(0, 15) == 0) bus.dm_req = 0;
      else if (!bus.dm_req && $urandom_range(0, 3) == 0) begin
        bus.dm_req = 1;
        bus.dm_addr = rand_addr();
        bus.dm_access_size = 2'($urandom_range(0, 3));
        bus.dm_rw = 1'($urandom_range(0, 1));
      end
    end
    reset_n = 1'b1;
    bus.if_req = 0; bus.dm_req = 0; bus.mem_busy = 0;
    repeat (40) tick();
    check("drain_idle", bus.mem_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
